// File: rtl/tc_pkg.sv
// Shared types and constants for the tc scheduler family.
package tc_pkg;

  // Scheduler FSM: arbitrate, pass one packet through, then hold the idle gap.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } tc_sched_state_e;

  // Default port count and the grant index width that goes with it.
  localparam int TC_NUM_PORTS = 4;
  localparam int TC_GRANT_W   = $clog2(TC_NUM_PORTS);

endpackage

// File: rtl/tc_rr_arb.sv
// Combinational round-robin picker: first set request searching upward
// from last_grant+1, wrapping modulo NUM_PORTS.
module tc_rr_arb
  import tc_pkg::*;
#(
  parameter int NUM_PORTS = TC_NUM_PORTS
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] last_grant,
  output logic [$clog2(NUM_PORTS)-1:0] gnt_idx,
  output logic                         gnt_vld
);

  localparam int GW = $clog2(NUM_PORTS);

  // Walk the offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int unsigned pos;
    pos     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      pos = (32'(last_grant) + 32'(k)) % 32'(NUM_PORTS);
      if (req[pos[GW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = pos[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/tc_sched.sv
// Packet-level round-robin scheduler sharing one AXI-Stream master between
// NUM_PORTS requesters, with a programmable idle gap after every packet.
//
// Handshake: a beat moves on a cycle where tvalid and tready are both high.
// In XFER the granted slave sees the master's tready unchanged and the master
// sees the slave's tvalid unchanged, so stability of tvalid/data under
// backpressure is the source's duty; all other readies stay low.
module tc_sched
  import tc_pkg::*;
#(
  parameter int NUM_PORTS   = TC_NUM_PORTS,
  parameter int TDATA_WIDTH = 512,
  parameter int TUSER_WIDTH = 1,
  parameter int GAP_WIDTH   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [GAP_WIDTH-1:0]                 cfg_gap,
  input  logic [NUM_PORTS-1:0]                 cfg_port_en,
  input  logic [NUM_PORTS*TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [NUM_PORTS*TDATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                 s_axis_tlast,
  input  logic [NUM_PORTS-1:0]                 s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                 s_axis_tready,
  output logic [TDATA_WIDTH-1:0]               m_axis_tdata,
  output logic [TDATA_WIDTH/8-1:0]             m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]               m_axis_tuser,
  output logic                                 m_axis_tlast,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [$clog2(NUM_PORTS)-1:0]         grant,
  output logic                                 busy,
  output logic [1:0]                           dbg_state
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int KW = TDATA_WIDTH / 8;

  tc_sched_state_e        state_q, state_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [GW-1:0]          last_grant_q, last_grant_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [NUM_PORTS-1:0]   req;
  logic [GW-1:0]          pick_idx;
  logic                   pick_vld;
  logic                   tlast_hs;

  assign req = s_axis_tvalid & cfg_port_en;

  tc_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req        (req),
    .last_grant (last_grant_q),
    .gnt_idx    (pick_idx),
    .gnt_vld    (pick_vld)
  );

  // Pass-through mux: only the granted port is connected, and only in XFER.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state_q == ST_XFER) begin
      m_axis_tdata           = s_axis_tdata[grant_q*TDATA_WIDTH +: TDATA_WIDTH];
      m_axis_tkeep           = s_axis_tkeep[grant_q*KW +: KW];
      m_axis_tuser           = s_axis_tuser[grant_q*TUSER_WIDTH +: TUSER_WIDTH];
      m_axis_tlast           = s_axis_tlast[grant_q];
      m_axis_tvalid          = s_axis_tvalid[grant_q];
      s_axis_tready[grant_q] = m_axis_tready;
    end
  end

  assign tlast_hs  = (state_q == ST_XFER) && m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign busy      = (state_q == ST_XFER);
  assign grant     = grant_q;
  assign dbg_state = state_q;

  // Next-state: arbitrate in IDLE, leave XFER on the tlast beat, count down the gap.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    gap_d        = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          state_d      = ST_XFER;
        end
      end
      ST_XFER: begin
        if (tlast_hs) begin
          if (cfg_gap == '0) begin
            state_d = ST_IDLE;
          end else begin
            gap_d   = cfg_gap;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_q - GAP_WIDTH'(1);
        if (gap_q == GAP_WIDTH'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; port 0 has first priority out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_PORTS - 1);
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      gap_q        <= gap_d;
    end
  end

endmodule

// File: tb/tb_tc_sched.sv
// Bench for tc_sched: per-port packet sources, a round-robin reference model
// that fills an expected-beat queue, and a negedge monitor that pops and checks.
module tb_tc_sched;

  localparam int N    = 4;
  localparam int DW   = 64;
  localparam int KW   = DW / 8;
  localparam int UW   = 1;
  localparam int GAPW = 16;
  localparam int GW   = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [GAPW-1:0]   cfg_gap;
  logic [N-1:0]      cfg_port_en;
  logic [N*DW-1:0]   s_axis_tdata;
  logic [N*KW-1:0]   s_axis_tkeep;
  logic [N*UW-1:0]   s_axis_tuser;
  logic [N-1:0]      s_axis_tlast;
  logic [N-1:0]      s_axis_tvalid;
  logic [N-1:0]      s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [KW-1:0]     m_axis_tkeep;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [GW-1:0]     grant;
  logic              busy;
  logic [1:0]        dbg_state;

  tc_sched #(.NUM_PORTS(N), .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .GAP_WIDTH(GAPW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_gap       (cfg_gap),
    .cfg_port_en   (cfg_port_en),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .grant         (grant),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- bench state ----------------
  beat_t src_q[N][$];       // beats each source still has to present
  beat_t model_q[N][$];     // model copy of pending beats per port
  int    model_len[N][$];   // model copy of pending packet lengths per port
  int    model_lg;          // model last-grant pointer
  beat_t exp_q[$];          // expected output beats in order
  int    exp_port_q[$];     // port expected to own each of those beats
  logic  rdy_pat[$];        // scripted m_axis_tready values, consumed first
  bit    rand_rdy = 1'b0;
  int    total = 0;
  int    bad = 0;
  int    scen = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = KW'($urandom);
      b.user = UW'($urandom);
      b.last = (i == len - 1);
      src_q[p].push_back(b);
      model_q[p].push_back(b);
    end
    model_len[p].push_back(len);
  endtask

  // Reference: whole packets in round-robin order among enabled ports that
  // have a pending packet; en_first applies to the first pick only.
  task automatic model_sched(input logic [N-1:0] en_first, input logic [N-1:0] en_rest);
    logic [N-1:0] en;
    int pick;
    int len;
    bit first;
    first = 1'b1;
    forever begin
      en = first ? en_first : en_rest;
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (model_lg + k) % N;
        if (pick < 0 && en[p] && model_len[p].size() > 0) pick = p;
      end
      if (pick < 0) break;
      first = 1'b0;
      model_lg = pick;
      len = model_len[pick].pop_front();
      repeat (len) begin
        exp_q.push_back(model_q[pick].pop_front());
        exp_port_q.push_back(pick);
      end
    end
  endtask

  task automatic drop_port(input int p);
    src_q[p].delete();
    model_q[p].delete();
    model_len[p].delete();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout: got=%0d beats left expected=0", exp_q.size());
      exp_q.delete();
      exp_port_q.delete();
    end
    repeat (int'(cfg_gap) + 8) @(negedge clk);
  endtask

  task automatic wait_first_beat();
    int n0;
    int t;
    n0 = exp_q.size();
    t = 0;
    while (exp_q.size() == n0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (exp_q.size() == n0) begin
      bad++;
      $display("FAIL first_beat_timeout: got=%0d expected<%0d", exp_q.size(), n0);
    end
  endtask

  // ---------------- source driver ----------------
  // Handshakes are sampled at negedge; queues advance and inputs change 1ns after posedge.
  initial begin
    logic [N-1:0] hs;
    beat_t b;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = '0;
    s_axis_tvalid = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      hs = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) begin
        if (hs[p] && src_q[p].size() > 0) b = src_q[p].pop_front();
        if (src_q[p].size() > 0) begin
          b = src_q[p][0];
          s_axis_tvalid[p]          = 1'b1;
          s_axis_tdata[p*DW +: DW]  = b.data;
          s_axis_tkeep[p*KW +: KW]  = b.keep;
          s_axis_tuser[p*UW +: UW]  = b.user;
          s_axis_tlast[p]           = b.last;
        end else begin
          s_axis_tvalid[p]          = 1'b0;
          s_axis_tdata[p*DW +: DW]  = '0;
          s_axis_tkeep[p*KW +: KW]  = '0;
          s_axis_tuser[p*UW +: UW]  = '0;
          s_axis_tlast[p]           = 1'b0;
        end
      end
      if (rdy_pat.size() > 0) m_axis_tready = rdy_pat.pop_front();
      else if (rand_rdy)      m_axis_tready = 1'($urandom_range(0, 1));
      else                    m_axis_tready = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit    in_gap;
    int    gap_cnt;
    int    gap_exp;
    int    gap_scen;
    int    ep;
    beat_t got;
    beat_t expb;
    logic [N-1:0] er;
    in_gap = 1'b0;
    gap_cnt = 0;
    gap_exp = 0;
    gap_scen = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_gap = 1'b0;
      end else begin
        if (m_axis_tvalid && in_gap) begin
          if (gap_scen == scen) chk("gap_cycles", 128'(gap_cnt), 128'(gap_exp));
          in_gap = 1'b0;
        end
        if (!m_axis_tvalid && in_gap) gap_cnt++;

        if (m_axis_tvalid) begin
          if (exp_port_q.size() == 0) begin
            chk("unexpected_valid", 128'(m_axis_tvalid), 128'(0));
          end else begin
            ep = exp_port_q[0];
            er = m_axis_tready ? (N'(1) << ep) : '0;
            chk("grant", 128'(grant), 128'(ep));
            chk("s_tready", 128'(s_axis_tready), 128'(er));
            chk("busy", 128'(busy), 128'(1));
          end
        end else begin
          chk("idle_s_tready", 128'(s_axis_tready), 128'(0));
        end

        if (m_axis_tvalid && m_axis_tready) begin
          got = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 128'(got), 128'(0));
          end else begin
            expb = exp_q.pop_front();
            ep = exp_port_q.pop_front();
            chk("beat", 128'(got), 128'(expb));
          end
          if (m_axis_tlast) begin
            in_gap = 1'b1;
            gap_cnt = 0;
            gap_exp = int'(cfg_gap) + 1;
            gap_scen = scen;
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    cfg_gap = '0;
    cfg_port_en = '1;
    model_lg = N - 1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("rst_tdata", 128'(m_axis_tdata), 128'(0));
    chk("rst_s_tready", 128'(s_axis_tready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant", 128'(grant), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All four ports, one 3-beat packet each, no gap: order 0,1,2,3.
    scen++;
    for (int p = 0; p < N; p++) add_pkt(p, 3);
    model_sched('1, '1);
    drain();

    // Last grant is 3; ports 0 and 3 request -> 0 wins by wrap-around.
    scen++;
    add_pkt(3, 2);
    add_pkt(0, 2);
    model_sched('1, '1);
    drain();

    // Port 0 disabled mid-packet: its packet completes, its next one waits.
    scen++;
    add_pkt(0, 4); add_pkt(0, 4);
    add_pkt(1, 2); add_pkt(1, 2);
    model_sched(4'b1111, 4'b1110);
    wait_first_beat();
    cfg_port_en = 4'b1110;
    drain();
    drop_port(0);
    repeat (3) @(negedge clk);
    cfg_port_en = '1;

    // Gap of 5 with a single requester: 6 idle cycles between packets.
    scen++;
    cfg_gap = 16'd5;
    add_pkt(2, 2); add_pkt(2, 2);
    model_sched('1, '1);
    drain();

    // Scripted backpressure on a 4-beat packet from port 1.
    scen++;
    cfg_gap = '0;
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    add_pkt(1, 4);
    model_sched('1, '1);
    drain();

    // Port 2 disabled while every port requests: port 2 never granted.
    scen++;
    cfg_port_en = 4'b1011;
    for (int p = 0; p < N; p++) begin
      add_pkt(p, $urandom_range(1, 4));
      add_pkt(p, $urandom_range(1, 4));
    end
    model_sched(4'b1011, 4'b1011);
    drain();
    drop_port(2);
    repeat (3) @(negedge clk);
    cfg_port_en = '1;

    // Randomized traffic with random gaps and random backpressure.
    rand_rdy = 1'b1;
    repeat (6) begin
      scen++;
      cfg_gap = 16'($urandom_range(0, 3));
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 2)) add_pkt(p, $urandom_range(1, 5));
        end
      end
      model_sched('1, '1);
      drain();
    end
    rand_rdy = 1'b0;

    // Reset mid-packet on port 2, then ports 1 and 3: port 1 must go first.
    scen++;
    cfg_gap = '0;
    add_pkt(2, 8);
    model_sched('1, '1);
    wait_first_beat();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("midrst_s_tready", 128'(s_axis_tready), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    for (int p = 0; p < N; p++) drop_port(p);
    exp_q.delete();
    exp_port_q.delete();
    model_lg = N - 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    scen++;
    add_pkt(3, 2);
    add_pkt(1, 2);
    model_sched('1, '1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound in case something stalls outside the drain loops.
  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/tc_sched.md
Name: tc_sched

Overview:
Packet-level scheduler in front of the tc shaping datapath. It shares one AXI-Stream master between NUM_PORTS requesters using round-robin arbitration at packet boundaries. It also enforces a programmable idle gap after every packet. It sequences whole packets only and never interleaves beats from different ports.

Parameters:
NUM_PORTS, 4, number of requesting AXI-Stream slave ports (2..16)
TDATA_WIDTH, 512, stream data width in bits
TUSER_WIDTH, 1, stream sideband width in bits
GAP_WIDTH, 16, width of the gap counter and cfg_gap

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
cfg_gap  in  GAP_WIDTH  idle cycles inserted after each packet's tlast
cfg_port_en  in  NUM_PORTS  per-port arbitration enable
s_axis_tdata  in  NUM_PORTS*TDATA_WIDTH  port i occupies slice [i*TDATA_WIDTH +: TDATA_WIDTH]
s_axis_tkeep  in  NUM_PORTS*TDATA_WIDTH/8  per-port keep, same slicing
s_axis_tuser  in  NUM_PORTS*TUSER_WIDTH  per-port user, same slicing
s_axis_tlast  in  NUM_PORTS  per-port last
s_axis_tvalid  in  NUM_PORTS  per-port valid
s_axis_tready  out  NUM_PORTS  per-port ready
m_axis_tdata  out  TDATA_WIDTH  to tc
m_axis_tkeep  out  TDATA_WIDTH/8  to tc
m_axis_tuser  out  TUSER_WIDTH  to tc
m_axis_tlast  out  1  to tc
m_axis_tvalid  out  1  to tc
m_axis_tready  in  1  from tc
grant  out  $clog2(NUM_PORTS)  index of the port owning the output (valid while busy)
busy  out  1  high in XFER

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, grant=0, last-grant pointer=NUM_PORTS-1 (port 0 has first priority), gap counter=0.
- Outputs during reset and outside XFER: m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0, s_axis_tready=0, busy=0.
- State IDLE:
  - req = s_axis_tvalid & cfg_port_en.
  - If req≠0, the round-robin picker selects the first set bit searching upward from last_grant+1, wrapping modulo NUM_PORTS.
  - Register grant and last_grant from that pick, then go to XFER.
  - Arbitration costs exactly one cycle; no beat is transferred in IDLE.
- State XFER:
  - Pure combinational pass-through, no added latency.
  - m_axis_* = s_axis_*[grant]; s_axis_tready[grant] = m_axis_tready; every other s_axis_tready = 0.
  - On a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast:
    - cfg_gap==0 -> IDLE.
    - otherwise -> GAP with the counter loaded from cfg_gap, sampled on that cycle.
- State GAP:
  - All readies 0, m_axis_tvalid 0.
  - Counter decrements by 1 per cycle; when counter==1, go to IDLE.
  - GAP therefore lasts exactly cfg_gap cycles.
- Spacing: cycles strictly between the tlast beat and the next packet's first possible beat = cfg_gap+1 (gap plus the IDLE arbitration cycle).
- Changes to cfg_port_en and cfg_gap take effect only at the next arbitration or tlast; an in-flight packet always completes, even if its port is disabled mid-packet.
- No timeout: if the granted port drops tvalid mid-packet, the scheduler waits in XFER indefinitely.
- Backpressure: m_axis_tready low holds everything; the slave sees tready low, so the AXI rule that tvalid is held stable is the source's duty.
- Single-requester case: the same port is re-granted after the gap; no starvation guard is needed beyond round-robin.
- Simultaneous tlast and new requests: the new requests are evaluated only in IDLE, never in the tlast cycle.
- Asserting rst_n low mid-packet aborts the packet immediately. The resulting truncated output stream is acceptable and is documented for software.

Decomposition:
- tc_pkg holds:
  - typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_GAP} tc_sched_state_e;
  - localparam for the grant width.
- One sub-module, tc_rr_arb. It is purely combinational: inputs req[NUM_PORTS] and last_grant; outputs gnt_idx and gnt_vld. It is reused by later multi-port tc variants.

Test Plan:
- Reset then 4 ports each offering one 3-beat packet simultaneously, cfg_gap=0, all enabled -> grant order 0,1,2,3. Each packet is followed by exactly 1 idle cycle, and output data matches per-port patterns.
- cfg_gap=5, port 2 only, two back-to-back 2-beat packets -> exactly 6 cycles with m_axis_tvalid=0 between the first tlast and the second packet's first beat.
- m_axis_tready toggled 1,0,0,1 during a 4-beat packet from port 1 -> no beat lost or duplicated, and s_axis_tready[1] mirrors m_axis_tready.
- cfg_port_en=4'b1011 with all ports valid -> port 2 is never granted. Clearing bit 0 mid-packet from port 0 still delivers its full packet.
- last_grant=3 with requests on ports 0 and 3 -> port 0 granted next (wrap-around check).
- rst_n pulsed low mid-packet -> m_axis_tvalid=0 and all s_axis_tready=0 in the same cycle. After release, arbitration restarts with port 0 highest priority.
